booth_mul_ctrl: RTL and testbench
=================================

BOOTH_MUL_CTRL -- requirements
Module: booth_mul_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 8-bit operands and a 16-bit product.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a multiply; sampled only in IDLE.
REQ-005 a  input  8  multiplicand, two's complement; sampled with start.
REQ-006 b  input  8  multiplier, two's complement; sampled with start.
REQ-007 busy  output  1  high while iterating (state RUN).
REQ-008 done  output  1  one-cycle pulse; product valid.
REQ-009 product  output  16  signed a*b; held until the next accepted start.
REQ-010 add_x  output  8  x operand to the shared adder.
REQ-011 add_y  output  8  y operand to the shared adder.
REQ-012 add_flag  output  1  adder mode: 1 = x+y, 0 = x-y.
REQ-013 add_z  input  9  adder result: the exact 9-bit signed x±y, combinational, same cycle.

Function
REQ-014 The block SHALL run the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 IDLE transitions:
- start=1 at an edge: load M<=a, Q<=b, A<=0 (8b), q1<=0, cnt<=0; go to RUN.
- start=0: stay in IDLE.
REQ-016 RUN SHALL perform one Booth radix-2 iteration per cycle, for exactly 8 cycles.
REQ-017 Adder drive in RUN: add_x=A.
- {Q[0],q1}=01: add_y=M, add_flag=1.
- {Q[0],q1}=10: add_y=M, add_flag=0.
- 00 or 11: add_y=0, add_flag=1.
REQ-018 Each RUN edge SHALL update A<=add_z[8:1], Q<={add_z[0],Q[7:1]}, q1<=Q[0], cnt<=cnt+1.
- This is an arithmetic shift of the full 9-bit sum, so M=-128 cases are exact.
REQ-019 On the RUN edge with cnt=7:
- Load product<={add_z[8:1],add_z[0],Q[7:1]} (the post-shift {A,Q}).
- Go to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Timing for start sampled at edge E0:
- busy=1 from E0 to E8.
- done=1 from E8 to E9.
- New product visible from E8.
REQ-022 start SHALL be ignored in RUN and DONE; operands are not re-sampled and no request is queued.
REQ-023 start high in the first IDLE cycle after DONE SHALL be accepted: back-to-back throughput is one result per 10 cycles.
REQ-024 In IDLE and DONE, drive add_x=0, add_y=0, add_flag=1.
REQ-025 a and b changing during RUN SHALL have no effect on the result.
REQ-026 busy and done SHALL decode from state only; they are never high simultaneously.

Reset
REQ-027 With rst=1 at an edge, the block SHALL go to IDLE and clear busy=0, done=0, product=0, A=0, Q=0, M=0, q1=0, cnt=0.
REQ-028 Reset SHALL take priority over start and over any RUN or DONE activity.
- Reset mid-operation aborts with no done pulse.
- product stays 0 until a fresh run completes.

Verification
REQ-029 Check: a=3, b=5, start for one cycle -> busy for 8 cycles, then done pulse, product=0x000F.
REQ-030 Check: a=8, b=-5 (0xFB) -> product=0xFFD8 (-40); a=-1, b=-1 -> product=0x0001.
REQ-031 Check the extremes:
- a=-128, b=-128 -> product=0x4000.
- a=-128, b=127 -> product=0xC080.
- a=0, b=0x7F -> product=0x0000.
REQ-032 Start ignored while busy: first multiply 3*5; pulse start with a=2, b=2 at RUN cycle 4 -> single done with product=0x000F; no second done without a new start in IDLE.
REQ-033 Reset mid-operation and recovery:
- Assert rst in RUN cycle 5 -> next cycle busy=0, done=0, product=0, and done never pulses.
- A following 7*(-3) -> product=0xFFEB.
REQ-034 Adder interface checks:
- Bench models the adder from REQ-013.
- Assert add_flag/add_y match {Q[0],q1} every RUN cycle.
- Assert idle drive values from REQ-024.
- Compare every product against a*b over at least 1000 random pairs.

Source files
------------

// File: rtl/booth_mul_ctrl_if.sv
// Operand, result and shared-adder signals of the Booth multiplier controller.
// slave is the controller side; master is the requester/adder side.
interface booth_mul_ctrl_if;
   logic        start;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic [7:0]  add_x;
   logic [7:0]  add_y;
   logic        add_flag;
   logic [8:0]  add_z;

   modport slave (
      input  start, a, b, add_z,
      output busy, done, product, add_x, add_y, add_flag
   );

   modport master (
      output start, a, b, add_z,
      input  busy, done, product, add_x, add_y, add_flag
   );
endinterface

// File: rtl/booth_mul_ctrl.sv
// Radix-2 Booth controller for signed 8x8 -> 16 multiply. The add/subtract
// is done by an external shared adder; this block sequences it for 8 cycles.
module booth_mul_ctrl (
   input logic             clk,
   input logic             rst,
   booth_mul_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  m;
   logic [7:0]  acc;
   logic [7:0]  q;
   logic        q1;
   logic [2:0]  cnt;
   logic [15:0] product;
   logic [7:0]  add_x, add_y;
   logic        add_flag;
   logic [8:0]  z;

   assign z = bus.add_z;

   // State register; reset wins over everything.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and adder drive; adder idles as 0+0 outside RUN.
   always_comb begin
      state_nxt = state;
      add_x     = 8'd0;
      add_y     = 8'd0;
      add_flag  = 1'b1;
      case (state)
         IDLE: if (bus.start) state_nxt = RUN;
         RUN: begin
            add_x = acc;
            case ({q[0], q1})
               2'b01:   begin add_y = m; add_flag = 1'b1; end
               2'b10:   begin add_y = m; add_flag = 1'b0; end
               default: begin add_y = 8'd0; add_flag = 1'b1; end
            endcase
            if (cnt == 3'd7) state_nxt = DONE;
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: operand capture in IDLE, shift of the 9-bit sum in RUN.
   // Shifting the full 9-bit sum keeps M=-128 exact.
   always_ff @(posedge clk) begin
      if (rst) begin
         m       <= 8'd0;
         acc     <= 8'd0;
         q       <= 8'd0;
         q1      <= 1'b0;
         cnt     <= 3'd0;
         product <= 16'd0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               m   <= bus.a;
               q   <= bus.b;
               acc <= 8'd0;
               q1  <= 1'b0;
               cnt <= 3'd0;
            end
            RUN: begin
               acc <= z[8:1];
               q   <= {z[0], q[7:1]};
               q1  <= q[0];
               cnt <= cnt + 3'd1;
               if (cnt == 3'd7) product <= {z[8:1], z[0], q[7:1]};
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = (state == RUN);
   assign bus.done     = (state == DONE);
   assign bus.product  = product;
   assign bus.add_x    = add_x;
   assign bus.add_y    = add_y;
   assign bus.add_flag = add_flag;
endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Directed and random checks of booth_mul_ctrl with a behavioural shared adder.
module tb_booth_mul_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;

   booth_mul_ctrl_if bus ();

   booth_mul_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Exact 9-bit signed adder/subtractor
   always_comb begin
      if (bus.add_flag) bus.add_z = {bus.add_x[7], bus.add_x} + {bus.add_y[7], bus.add_y};
      else              bus.add_z = {bus.add_x[7], bus.add_x} - {bus.add_y[7], bus.add_y};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] smul(input logic signed [7:0] x, input logic signed [7:0] y);
      logic signed [15:0] xx, yy;
      xx = x;
      yy = y;
      return xx * yy;
   endfunction

   task automatic chk_idle(input string tag);
      chk({tag, "_busy"}, bus.busy, 0);
      chk({tag, "_done"}, bus.done, 0);
      chk({tag, "_ax"}, bus.add_x, 0);
      chk({tag, "_ay"}, bus.add_y, 0);
      chk({tag, "_af"}, bus.add_flag, 1);
   endtask

   // One multiply with a reference Booth model; optional start pulse at RUN cycle inj.
   task automatic run_mul(input logic [7:0] ai, input logic [7:0] bi,
                          input logic [15:0] ep, input int inj, input string tag);
      logic [7:0] ma, mq, ey;
      logic       mq1, ef;
      logic [8:0] z;
      bus.a = ai; bus.b = bi; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      ma = 8'd0; mq = bi; mq1 = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk({tag, "_busy_run"}, bus.busy, 1);
         chk({tag, "_done_run"}, bus.done, 0);
         case ({mq[0], mq1})
            2'b01:   begin ey = ai; ef = 1'b1; end
            2'b10:   begin ey = ai; ef = 1'b0; end
            default: begin ey = 8'd0; ef = 1'b1; end
         endcase
         chk({tag, "_ax"}, bus.add_x, ma);
         chk({tag, "_ay"}, bus.add_y, ey);
         chk({tag, "_af"}, bus.add_flag, ef);
         z = ef ? ({ma[7], ma} + {ey[7], ey}) : ({ma[7], ma} - {ey[7], ey});
         mq1 = mq[0];
         ma  = z[8:1];
         mq  = {z[0], mq[7:1]};
         if (i == inj) begin
            bus.a = 8'd2; bus.b = 8'd2; bus.start = 1'b1;
         end
         tick();
         bus.start = 1'b0;
      end
      chk({tag, "_done"}, bus.done, 1);
      chk({tag, "_busy_done"}, bus.busy, 0);
      chk({tag, "_prod"}, bus.product, ep);
      chk({tag, "_model"}, {ma, mq}, ep);
      chk({tag, "_done_ax"}, bus.add_x, 0);
      chk({tag, "_done_af"}, bus.add_flag, 1);
      tick();
      chk_idle({tag, "_idle"});
      chk({tag, "_hold"}, bus.product, ep);
   endtask

   typedef struct {logic [7:0] a; logic [7:0] b; logic [15:0] p;} vec_t;
   vec_t vecs[6] = '{
      '{8'h03, 8'h05, 16'h000F},
      '{8'h08, 8'hFB, 16'hFFD8},
      '{8'hFF, 8'hFF, 16'h0001},
      '{8'h80, 8'h80, 16'h4000},
      '{8'h80, 8'h7F, 16'hC080},
      '{8'h00, 8'h7F, 16'h0000}
   };

   initial begin
      bus.start = 1'b0; bus.a = 8'd0; bus.b = 8'd0;
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk_idle("reset");
      chk("reset_prod", bus.product, 0);
      tick();
      chk_idle("idle_wait");

      // directed vectors, issued back to back
      foreach (vecs[k]) run_mul(vecs[k].a, vecs[k].b, vecs[k].p, -1, $sformatf("vec%0d", k));

      // start pulse during RUN must be ignored
      run_mul(8'd3, 8'd5, 16'h000F, 3, "ign");
      for (int i = 0; i < 12; i++) begin
         chk("ign_no_done", bus.done, 0);
         chk("ign_no_busy", bus.busy, 0);
         tick();
      end
      chk("ign_prod_hold", bus.product, 16'h000F);

      // reset in RUN cycle 5 aborts without done
      bus.a = 8'd3; bus.b = 8'd5; bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("rst_mid_busy_pre", bus.busy, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rst_mid_busy", bus.busy, 0);
      chk("rst_mid_done", bus.done, 0);
      chk("rst_mid_prod", bus.product, 0);
      for (int i = 0; i < 10; i++) begin
         chk("rst_no_done", bus.done, 0);
         chk("rst_no_busy", bus.busy, 0);
         tick();
      end
      chk("rst_prod_zero", bus.product, 0);
      run_mul(8'd7, 8'hFD, 16'hFFEB, -1, "rec");

      // random pairs against signed a*b
      for (int i = 0; i < 1000; i++) begin
         logic [7:0] ra, rb;
         ra = 8'($urandom);
         rb = 8'($urandom);
         run_mul(ra, rb, smul(ra, rb), -1, "rnd");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
